// File: rtl/bus_pkg.sv
// Shared bus definitions: slave FSM state encoding, read/write mode values, sizing helper.
// Pure declarations, no logic.
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_WDATA      = 3'd2,
        ST_MEMWR      = 3'd3,
        ST_SPLIT      = 3'd4,
        ST_WAIT_GRANT = 3'd5,
        ST_MEMRD      = 3'd6,
        ST_RDATA      = 3'd7
    } state_t;

    localparam logic MODE_RD = 1'b0;
    localparam logic MODE_WR = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift.sv
// LSB-first shift register with parallel load; single-cycle load/shift, load wins over shift.
// No backpressure: acts only when load_i/shift_i are asserted.
module serial_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_dat_i;
        end else if (shift_i) begin
            // New bit enters at the MSB so the first bit received ends up at bit 0.
            data_d = (data_q >> 1) | (WIDTH'(sin_i) << (WIDTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sout_o = data_q[0];
    assign q_o    = data_q;

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: bit-serial address/data in, memory strobe, optional split, bit-serial read data out.
// Write strobe 1 cycle after last data bit; mvalid=0 stalls input phases, read return never stalls.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter bit SPLIT_EN     = 1'b0,
    parameter int SPLIT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic                  ssplit,
    input  logic                  split_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int CW  = $clog2(max2(ADDR_WIDTH, DATA_WIDTH)) + 1;
    localparam int SCW = $clog2(SPLIT_CYCLES + 1);
    localparam logic [CW-1:0]  ADDR_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]  DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [SCW-1:0] SPLIT_LAST = SCW'(SPLIT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           mode_q, mode_d;
    logic           ren_done_q, ren_done_d;

    logic addr_shift, wd_shift, rd_load, rd_shift, addr_done, cur_mode;
    logic addr_sout, wd_sout, rd_sout;
    logic [DATA_WIDTH-1:0] rd_par;
    logic unused_bits;

    serial_shift #(.WIDTH(ADDR_WIDTH)) u_addr (
        .clk(clk), .rstn(rstn), .load_i(1'b0), .load_dat_i('0),
        .shift_i(addr_shift), .sin_i(swdata), .sout_o(addr_sout), .q_o(mem_addr)
    );

    serial_shift #(.WIDTH(DATA_WIDTH)) u_wdata (
        .clk(clk), .rstn(rstn), .load_i(1'b0), .load_dat_i('0),
        .shift_i(wd_shift), .sin_i(swdata), .sout_o(wd_sout), .q_o(mem_wdata)
    );

    serial_shift #(.WIDTH(DATA_WIDTH)) u_rdata (
        .clk(clk), .rstn(rstn), .load_i(rd_load), .load_dat_i(mem_rdata),
        .shift_i(rd_shift), .sin_i(1'b0), .sout_o(rd_sout), .q_o(rd_par)
    );

    assign unused_bits = ^{addr_sout, wd_sout, rd_par};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            scnt_q     <= '0;
            mode_q     <= MODE_RD;
            ren_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scnt_q     <= scnt_d;
            mode_q     <= mode_d;
            ren_done_q <= ren_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scnt_d     = scnt_q;
        mode_d     = mode_q;
        ren_done_d = ren_done_q;
        addr_shift = 1'b0;
        wd_shift   = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;
        addr_done  = 1'b0;
        // Mode is only registered at the first bit, so use the live pin in IDLE.
        cur_mode   = (state_q == ST_IDLE) ? smode : mode_q;

        unique case (state_q)
            ST_IDLE, ST_ADDR: begin
                if (mvalid) begin
                    if (state_q == ST_IDLE) mode_d = smode;
                    addr_shift = 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        addr_done = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_WDATA: begin
                if (mvalid) begin
                    wd_shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_MEMWR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_MEMWR: state_d = ST_IDLE;
            ST_SPLIT: begin
                if (scnt_q == SPLIT_LAST) state_d = ST_WAIT_GRANT;
                else                      scnt_d  = scnt_q + 1'b1;
            end
            ST_WAIT_GRANT: begin
                if (split_grant) state_d = ST_MEMRD;
            end
            ST_MEMRD: begin
                // The strobe cycle itself never accepts data; rvalid counts from the next cycle.
                ren_done_d = 1'b1;
                if (ren_done_q && mem_rvalid) begin
                    rd_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rd_shift = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (addr_done) begin
            cnt_d      = '0;
            scnt_d     = '0;
            ren_done_d = 1'b0;
            if (cur_mode == MODE_WR) state_d = ST_WDATA;
            else if (SPLIT_EN)       state_d = ST_SPLIT;
            else                     state_d = ST_MEMRD;
        end
    end

    always_comb begin
        sready  = (state_q == ST_IDLE);
        ssplit  = (state_q == ST_SPLIT);
        mem_wen = (state_q == ST_MEMWR);
        mem_ren = (state_q == ST_MEMRD) && !ren_done_q;
        svalid  = (state_q == ST_RDATA);
        srdata  = (state_q == ST_RDATA) ? rd_sout : 1'b0;
    end

endmodule
